// File: rtl/chip8_mem_pkg.sv
// Shared constants and types for the CHIP-8 multi-port memory arbiter.
//   FB_OFFSET_DEF / FB_LEN_DEF : framebuffer window defaults (match the GPU)
//   ARB_FIXED / ARB_RR         : arbitration mode selectors
//   clr_state_t                : framebuffer-clear sequencer states
package chip8_mem_pkg;

  localparam int unsigned FB_OFFSET_DEF = 'hF00;
  localparam int unsigned FB_LEN_DEF    = 256;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Single-grant arbiter for the CHIP-8 memory ports.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_i          : per-port request
//   mask_i         : per-port mask (1 = not eligible this cycle)
//   grant_o        : one-hot grant
//   grant_idx_o    : index of the granted port
//   grant_vld_o    : a grant was issued this cycle
// ARB_MODE selects fixed priority (lowest index wins) or round-robin
// (search starts at the pointer, pointer moves past the winner).
module mem_rr_arbiter
  import chip8_mem_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 2,
  parameter  int unsigned ARB_MODE  = ARB_FIXED,
  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] mask_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_vld_o
);

  logic [NUM_PORTS-1:0] eff;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx;
  logic                 found;

  always_comb begin : p_arb
    int unsigned cand;
    cand  = 0;
    eff   = req_i & ~mask_i;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = (ARB_MODE == ARB_RR) ? ((32'(ptr_q) + i) % NUM_PORTS) : i;
      if (!found && eff[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end

    grant_o = '0;
    if (found) grant_o[idx] = 1'b1;
    grant_idx_o = idx;
    grant_vld_o = found;

    ptr_d = ptr_q;
    if ((ARB_MODE == ARB_RR) && found) begin
      ptr_d = (32'(idx) == NUM_PORTS - 1) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// CHIP-8 main memory with multi-port arbitration, VRAM shadow of the
// framebuffer window, hardware framebuffer clear and a VGA read port.
//   clk, rst_n : clock, asynchronous active-low reset
//   req/we/addr/wdata : per-port request bundle, port p in slice p
//   ack        : one-cycle acknowledge, one cycle after the grant edge
//   rdata      : read data, valid while ack is high (held across writes)
//   fb_clear   : pulse to zero the framebuffer window (RAM and VRAM)
//   busy       : clear sequencer active; all ports are masked meanwhile
//   vga_addr / vga_data : registered VRAM read, independent of the arbiter
module chip8_mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 12,
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned NUM_PORTS = 2,
  parameter  int unsigned ARB_MODE  = ARB_FIXED,
  parameter  int unsigned FB_OFFSET = FB_OFFSET_DEF,
  parameter  int unsigned FB_LEN    = FB_LEN_DEF,
  parameter  string       INIT_FILE = "",
  localparam int unsigned VA_W      = $clog2(FB_LEN),
  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  input  logic                        fb_clear,
  output logic                        busy,
  input  logic [VA_W-1:0]             vga_addr,
  output logic [DATA_W-1:0]           vga_data
);

  // Window bounds at ADDR_W+1 bits so a window ending at 2**ADDR_W fits.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W + 1)'(FB_OFFSET);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W + 1)'(FB_OFFSET + FB_LEN);

  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [DATA_W-1:0] vram [FB_LEN];

  clr_state_t        state_q, state_d;
  logic [VA_W-1:0]   cnt_q, cnt_d;
  logic              clr_active;
  logic [ADDR_W-1:0] clr_addr;

  logic [NUM_PORTS-1:0] ack_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    vga_q;

  logic [NUM_PORTS-1:0] mask;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     gidx;
  logic                 gvld;

  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_we;
  logic              in_win;
  logic [VA_W-1:0]   win_idx;

  assign clr_active = (state_q == ST_CLEAR);
  assign clr_addr   = ADDR_W'(FB_OFFSET) + ADDR_W'(cnt_q);

  // A port whose ack is high is masked so it cannot be granted twice for
  // one request; the whole arbiter is masked while the clear runs.
  assign mask = clr_active ? '1 : ack_q;

  mem_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .mask_i      (mask),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .grant_vld_o (gvld)
  );

  always_comb begin
    g_addr  = addr[32'(gidx) * ADDR_W +: ADDR_W];
    g_wdata = wdata[32'(gidx) * DATA_W +: DATA_W];
    g_we    = we[gidx];
    in_win  = ({1'b0, g_addr} >= WIN_LO) && ({1'b0, g_addr} < WIN_HI);
    win_idx = VA_W'(g_addr - ADDR_W'(FB_OFFSET));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fb_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (32'(cnt_q) == FB_LEN - 1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      vga_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= grant;
      if (gvld && !g_we) rdata_q <= mem[g_addr];
      vga_q <= vram[vga_addr];
    end
  end

  // Storage is not reset; a reset mid-clear leaves the window partially
  // cleared. Port grants never coincide with clear writes (masked).
  always_ff @(posedge clk) begin
    if (clr_active) begin
      mem[clr_addr] <= '0;
      vram[cnt_q]   <= '0;
    end else if (gvld && g_we) begin
      mem[g_addr] <= g_wdata;
      if (in_win) vram[win_idx] <= g_wdata;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = clr_active;
  assign vga_data = vga_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
module tb_chip8_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam logic [11:0] FBO = 12'hF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [1:0]     req, we, ack;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [DW-1:0]  rdata, vga_data;
  logic           fb_clear, busy;
  logic [7:0]     vga_addr;

  logic [2:0]     req3, we3, ack3;
  logic [3*AW-1:0] addr3;
  logic [3*DW-1:0] wdata3;
  logic [DW-1:0]  rdata3, vga_data3;
  logic           fb_clear3, busy3;
  logic [7:0]     vga_addr3;

  chip8_mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .fb_clear(fb_clear), .busy(busy),
    .vga_addr(vga_addr), .vga_data(vga_data)
  );

  chip8_mem_arbiter #(.NUM_PORTS(3), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .ack(ack3), .rdata(rdata3), .fb_clear(fb_clear3), .busy(busy3),
    .vga_addr(vga_addr3), .vga_data(vga_data3)
  );

  // Reference: flat byte memory; VRAM is by definition the window of it.
  logic [7:0]  ref_mem   [4096];
  bit          ref_known [4096];
  logic [11:0] known_q[$];
  logic [7:0]  last_rd;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_pick(input int n, input logic [2:0] r, input int start);
    for (int off = 0; off < n; off++) begin
      int p = (start + off) % n;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic xact(input int p, input bit w, input logic [11:0] a,
                      input logic [7:0] d, input bit check_lat);
    int lat;
    bit got;
    req[p] = 1'b1;
    we[p]  = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      got = ack[p];
    end
    chk("ack_seen", 32'(got), 1);
    if (check_lat) chk("ack_latency", lat, 1);
    chk("ack_onehot", 32'(ack), 32'(1) << p);
    if (w) begin
      chk("rdata_hold", 32'(rdata), 32'(last_rd));
      ref_mem[a]   = d;
      ref_known[a] = 1'b1;
    end else begin
      last_rd = ref_mem[a];
      chk("rdata", 32'(rdata), 32'(last_rd));
    end
    req[p] = 1'b0;
    we[p]  = 1'b0;
    tick();
    chk("ack_idle", 32'(ack), 0);
  endtask

  task automatic vga_chk(input logic [7:0] idx, input string tag);
    vga_addr = idx;
    tick();
    if (ref_known[FBO + 12'(idx)]) chk(tag, 32'(vga_data), 32'(ref_mem[FBO + 12'(idx)]));
  endtask

  initial begin
    int g, busy_cycles, mptr;
    logic [2:0] mack, r;
    logic [31:0] expv;
    logic [11:0] a;

    for (int i = 0; i < 4096; i++) ref_known[i] = 1'b0;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    fb_clear = 1'b0; vga_addr = '0;
    req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; fb_clear3 = 1'b0; vga_addr3 = '0;
    last_rd = 8'h00;

    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vga", 32'(vga_data), 0);
    chk("rst_ack3", 32'(ack3), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Round-robin: all held first, then random request patterns.
    mptr = 0;
    mack = '0;
    for (int k = 0; k < 40; k++) begin
      r = (k < 9) ? 3'b111 : 3'($urandom);
      req3 = r;
      tick();
      g = ref_pick(3, r & ~mack, mptr);
      expv = (g < 0) ? 32'd0 : (32'(1) << g);
      chk("rr_ack", 32'(ack3), expv);
      if (k < 9) chk("rr_seq", 32'(ack3), 32'(1) << (k % 3));
      if (g >= 0) mptr = (g + 1) % 3;
      mack = expv[2:0];
    end
    req3 = '0;
    tick();

    // Single write/read, window edges and aliasing.
    xact(0, 1'b1, 12'h200, 8'h6A, 1'b1);
    xact(0, 1'b0, 12'h200, 8'h00, 1'b1);
    xact(1, 1'b1, 12'hF10, 8'hFF, 1'b1);
    vga_chk(8'h10, "mirror_f10");
    xact(1, 1'b1, 12'hFFF, 8'h3C, 1'b1);
    xact(0, 1'b1, 12'hEFF, 8'hAA, 1'b1);
    vga_chk(8'hFF, "no_mirror_eff");
    xact(0, 1'b1, 12'hF00, 8'h11, 1'b1);
    xact(1, 1'b1, 12'hE00, 8'h99, 1'b1);
    vga_chk(8'h00, "no_mirror_e00");
    xact(1, 1'b0, 12'hEFF, 8'h00, 1'b1);
    known_q = '{12'h200, 12'hF10, 12'hFFF, 12'hEFF, 12'hF00, 12'hE00};

    // Fixed-priority contention: both held, then random patterns.
    mack = '0;
    addr = {12'hF10, 12'h200};
    for (int k = 0; k < 24; k++) begin
      r = (k < 6) ? 3'b011 : {1'b0, 2'($urandom)};
      req = r[1:0];
      tick();
      g = ref_pick(2, r & ~mack, 0);
      expv = (g < 0) ? 32'd0 : (32'(1) << g);
      chk("fixed_ack", 32'(ack), expv);
      if (k < 6) chk("fixed_alt", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (g == 0) last_rd = ref_mem[12'h200];
      if (g == 1) last_rd = ref_mem[12'hF10];
      chk("fixed_rdata", 32'(rdata), 32'(last_rd));
      mack = expv[2:0];
    end
    req = '0;
    tick(); tick();

    // Random single transactions with VRAM alias checks.
    for (int n = 0; n < 40; n++) begin
      int p;
      p = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        a = known_q[$urandom_range(0, known_q.size() - 1)];
        xact(p, 1'b0, a, 8'h00, 1'b1);
      end else begin
        case ($urandom_range(0, 3))
          0: a = FBO + 12'($urandom_range(0, 255));
          1: a = ($urandom_range(0, 1) == 0) ? 12'hEFF : 12'hFFF;
          default: a = 12'($urandom);
        endcase
        if (a == 12'h200) a = 12'h201;
        xact(p, 1'b1, a, 8'($urandom), 1'b1);
        known_q.push_back(a);
        vga_chk(a[7:0], "vga_alias");
      end
    end

    // Fill the window, then clear with a same-cycle grant.
    for (int i = 0; i < 256; i++) xact(i % 2, 1'b1, FBO + 12'(i), 8'h55, 1'b1);
    fb_clear = 1'b1;
    req[1] = 1'b1; we[1] = 1'b0; addr[AW +: AW] = 12'h200;
    tick();
    fb_clear = 1'b0;
    req[1] = 1'b0;
    chk("clr_same_cycle_ack", 32'(ack), 2);
    chk("clr_same_cycle_rdata", 32'(rdata), 32'(ref_mem[12'h200]));
    chk("clr_busy_start", 32'(busy), 1);
    last_rd = ref_mem[12'h200];
    req[0] = 1'b1; we[0] = 1'b0; addr[0 +: AW] = 12'hF64;
    busy_cycles = 1;
    while (busy && busy_cycles < 400) begin
      fb_clear = (busy_cycles == 50);
      tick();
      chk("clr_no_ack", 32'(ack), 0);
      if (busy) busy_cycles++;
    end
    fb_clear = 1'b0;
    chk("clr_busy_len", busy_cycles, 256);
    for (int i = 0; i < 256; i++) ref_mem[FBO + 12'(i)] = 8'h00;
    tick();
    chk("clr_pending_ack", 32'(ack), 1);
    chk("clr_pending_rdata", 32'(rdata), 0);
    last_rd = 8'h00;
    req[0] = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) vga_chk(8'(i), "clr_vram");
    xact(0, 1'b0, 12'hF00, 8'h00, 1'b1);
    xact(1, 1'b0, 12'hFFF, 8'h00, 1'b1);
    xact(0, 1'b0, 12'hEFF, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) xact(i % 2, 1'b0, FBO + 12'($urandom_range(0, 255)), 8'h00, 1'b1);

    // Asynchronous reset in the middle of a clear.
    for (int i = 0; i < 256; i++) xact(i % 2, 1'b1, FBO + 12'(i), 8'h55, 1'b1);
    xact(0, 1'b0, 12'h200, 8'h00, 1'b1);
    vga_chk(8'd200, "pre_rst_vga");
    fb_clear = 1'b1;
    tick();
    fb_clear = 1'b0;
    repeat (100) tick();
    chk("mid_clr_busy", 32'(busy), 1);
    chk("pre_rst_rdata", 32'(rdata), 32'h6A);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ack", 32'(ack), 0);
    chk("arst_rdata", 32'(rdata), 0);
    chk("arst_vga", 32'(vga_data), 0);
    for (int i = 0; i < 100; i++) ref_mem[FBO + 12'(i)] = 8'h00;
    last_rd = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    xact(0, 1'b0, 12'hF64, 8'h00, 1'b1);
    xact(1, 1'b0, 12'hF63, 8'h00, 1'b1);
    xact(0, 1'b0, 12'hF00, 8'h00, 1'b1);
    vga_chk(8'd99, "post_rst_vga99");
    vga_chk(8'd100, "post_rst_vga100");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
